// File: rtl/tmds_rx_word_aligner.sv
// TMDS lane word aligner: slides a 10-bit window until control-token runs appear.
// Define TMDS_ALIGN_STATS_EN to add the relock_cnt and slip_cnt outputs.
module tmds_rx_word_aligner #(
    parameter int LOCK_RUN      = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int SETTLE        = 4,
    parameter int LOSS_WINDOW   = 4096
) (
    input  logic        pxl_clk,
    input  logic        rst_n,
    input  logic [9:0]  raw_word,
    output logic [9:0]  word_out,
    output logic        word_valid,
    output logic        ctrl_token,
    output logic [1:0]  ctrl_code,
    output logic        locked,
    output logic [3:0]  bit_offset,
    output logic        slip_pulse
`ifdef TMDS_ALIGN_STATS_EN
    ,
    output logic [15:0] relock_cnt,
    output logic [7:0]  slip_cnt
`endif
);

    localparam int RUN_W  = $clog2(LOCK_RUN) + 1;
    localparam int WIN_W  = $clog2(SEARCH_WINDOW) + 1;
    localparam int SET_W  = $clog2(SETTLE) + 1;
    localparam int LOSS_W = $clog2(LOSS_WINDOW) + 1;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SETTLE,
        ST_LOCKED
    } state_t;

    state_t state, state_nxt;

    logic [9:0]        raw_d1, raw_d2;
    logic [19:0]       win;
    logic [RUN_W-1:0]  run_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [SET_W-1:0]  set_cnt;
    logic [LOSS_W-1:0] loss_cnt;
    logic              run_hit;
    logic              win_end;
    logic              set_end;
    logic              loss_end;
    logic              do_slip;

    // Two consecutive words give every 10-bit alignment of the bit stream.
    assign win = {raw_d1, raw_d2};

    always_comb begin
        ctrl_token = 1'b1;
        ctrl_code  = 2'd0;
        unique case (word_out)
            10'h354: ctrl_code = 2'd0;
            10'h0AB: ctrl_code = 2'd1;
            10'h154: ctrl_code = 2'd2;
            10'h2AB: ctrl_code = 2'd3;
            default: ctrl_token = 1'b0;
        endcase
    end

    // Fires only on the run's transition into LOCK_RUN, never while saturated.
    assign run_hit  = ctrl_token && (run_cnt == RUN_W'(LOCK_RUN - 1));
    assign win_end  = (win_cnt == WIN_W'(SEARCH_WINDOW - 1));
    assign set_end  = (set_cnt == SET_W'(SETTLE - 1));
    assign loss_end = (loss_cnt == LOSS_W'(LOSS_WINDOW - 1));

    always_comb begin
        state_nxt = state;
        do_slip   = 1'b0;
        unique case (state)
            ST_SEARCH: begin
                if (run_hit) begin
                    state_nxt = ST_LOCKED;
                end else if (win_end) begin
                    state_nxt = ST_SETTLE;
                    do_slip   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (set_end)
                    state_nxt = ST_SEARCH;
            end
            ST_LOCKED: begin
                if (!run_hit && loss_end)
                    state_nxt = ST_SEARCH;
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    always_ff @(posedge pxl_clk) begin
        if (!rst_n)
            state <= ST_SEARCH;
        else
            state <= state_nxt;
    end

    always_ff @(posedge pxl_clk) begin
        if (!rst_n) begin
            raw_d1     <= '0;
            raw_d2     <= '0;
            word_out   <= '0;
            slip_pulse <= 1'b0;
            bit_offset <= '0;
            run_cnt    <= '0;
            win_cnt    <= '0;
            set_cnt    <= '0;
            loss_cnt   <= '0;
        end else begin
            raw_d1     <= raw_word;
            raw_d2     <= raw_d1;
            word_out   <= win[{1'b0, bit_offset} +: 10];
            slip_pulse <= do_slip;
            if (do_slip)
                bit_offset <= (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
            if (do_slip || state == ST_SETTLE || !ctrl_token)
                run_cnt <= '0;
            else if (run_cnt != RUN_W'(LOCK_RUN))
                run_cnt <= run_cnt + RUN_W'(1);
            win_cnt <= (state == ST_SEARCH && state_nxt == ST_SEARCH)
                     ? win_cnt + WIN_W'(1) : '0;
            set_cnt <= (state == ST_SETTLE && state_nxt == ST_SETTLE)
                     ? set_cnt + SET_W'(1) : '0;
            // A freshly completed run in LOCKED restarts the loss timer.
            loss_cnt <= (state == ST_LOCKED && state_nxt == ST_LOCKED && !run_hit)
                      ? loss_cnt + LOSS_W'(1) : '0;
        end
    end

    assign locked     = (state == ST_LOCKED);
    assign word_valid = (state == ST_LOCKED);

`ifdef TMDS_ALIGN_STATS_EN
    always_ff @(posedge pxl_clk) begin
        if (!rst_n) begin
            relock_cnt <= '0;
            slip_cnt   <= '0;
        end else begin
            if (state == ST_LOCKED && state_nxt == ST_SEARCH
                && relock_cnt != 16'hFFFF)
                relock_cnt <= relock_cnt + 16'd1;
            if (state == ST_SEARCH && state_nxt == ST_LOCKED)
                slip_cnt <= '0;
            else if (do_slip)
                slip_cnt <= slip_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/tmds_rx_word_aligner.md
Name: tmds_rx_word_aligner

Overview:
- Receive-side counterpart to the HDMI TMDS serializer path: one instance per TMDS lane, clocked by pxl_clk.
- Takes the free-running 10-bit raw word produced each pixel clock by the lane deserializer, whose word boundary is arbitrary.
- Recovers the TMDS word boundary by hunting for runs of the four blanking-period control tokens, then outputs aligned 10-bit words plus a lock flag.
- Feeds the downstream TMDS decoder.

Parameters:
- LOCK_RUN, 8: consecutive control tokens required to declare lock or refresh lock.
- SEARCH_WINDOW, 2048: cycles spent at one bit offset before advancing; must exceed one video line.
- SETTLE, 4: cycles ignored after an offset change (pipeline flush).
- LOSS_WINDOW, 4096: cycles in LOCKED without a qualifying token run before lock is dropped.

Ports:
- pxl_clk  input  1  pixel clock, single clock domain.
- rst_n  input  1  synchronous active-low reset.
- raw_word  input  10  deserialized lane bits; bit0 = first bit on the wire. Sampled every cycle.
- word_out  output  10  aligned TMDS word.
- word_valid  output  1  high while locked; word_out is meaningful.
- ctrl_token  output  1  word_out is a control token.
- ctrl_code  output  2  {c1,c0} of the token; 0 when ctrl_token=0.
- locked  output  1  alignment achieved.
- bit_offset  output  4  current window offset, 0..9.
- slip_pulse  output  1  one-cycle pulse on each offset change, for optional ISERDES bitslip use.

Behaviour:
- Reset (rst_n=0 at a pxl_clk edge): all outputs 0, pipeline regs 0, state SEARCH, offset 0, all counters 0.
- Pipeline:
  - raw_d1 <= raw_word; raw_d2 <= raw_d1.
  - W = {raw_d1, raw_d2} (20 bits).
  - word_out <= W[offset+9 : offset].
  - With offset 0, word_out equals raw_word delayed 3 cycles.
- Token decode is combinational on word_out:
  - 0x354 -> code 0
  - 0x0AB -> code 1
  - 0x154 -> code 2
  - 0x2AB -> code 3
- run_cnt:
  - Increments on each ctrl_token cycle; clears on any non-token cycle.
  - Saturates at LOCK_RUN.
  - Cleared on every offset change.
- State SEARCH:
  - win_cnt counts cycles at the current offset.
  - If run_cnt reaches LOCK_RUN: go to LOCKED, locked=1, word_valid=1, loss_cnt=0.
  - Else, if win_cnt reaches SEARCH_WINDOW-1: offset <= (offset==9) ? 0 : offset+1, slip_pulse=1 for one cycle, go to SETTLE.
  - If lock and window expiry occur in the same cycle, lock wins.
- State SETTLE:
  - Counts SETTLE cycles; run_cnt is held at 0.
  - Then go to SEARCH with win_cnt=0.
- State LOCKED:
  - Offset frozen.
  - loss_cnt increments each cycle; it resets to 0 on the cycle run_cnt reaches LOCK_RUN.
  - Tokens in a run that continues beyond LOCK_RUN do not re-trigger the reset until the run breaks and re-forms.
  - If loss_cnt reaches LOSS_WINDOW-1: locked=0, word_valid=0, go to SEARCH at the same offset with win_cnt=0. No slip on this transition.
- ctrl_token and ctrl_code are valid in all states; word_valid gates their use downstream.
- Counter widths: clog2 of the respective parameter plus 1. No wrap inside a window.

Optional Feature:
- Macro: TMDS_ALIGN_STATS_EN.
- Defined:
  - Adds output relock_cnt[15:0].
  - Increments on each LOCKED->SEARCH transition; saturates at 0xFFFF.
  - Cleared only by rst_n.
  - Also adds output slip_cnt[7:0], counting slip_pulse events since the last lock (wraps); cleared on entry to LOCKED and by reset.
- Not defined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Continuous 0x354 from reset release -> word_out=0x354 from cycle 3, ctrl_code=0, locked=1 by cycle 11, bit_offset=0, slip_pulse never asserted.
- Bit stream of repeating 0x0AB rotated so the word boundary sits 3 bits late -> exactly 3 slip_pulses, bit_offset=3, locked=1, word_out=0x0AB, ctrl_code=1.
- Pseudo-random data containing no token runs -> offset steps 0..9 then 0 (wrap), slip every SEARCH_WINDOW+SETTLE cycles, locked stays 0.
- Lock achieved, then data only for 4096 cycles -> locked and word_valid fall exactly at LOSS_WINDOW, bit_offset unchanged, no slip_pulse.
- Aligned stream of 7x 0x154, one data word, then 8x 0x2AB -> no lock after the first run; lock on the 8th 0x2AB.
- rst_n low for one cycle while locked -> all outputs 0 at the next edge. With the macro defined, force two lock losses -> relock_cnt=2.
